// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding and bus constants.
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StWaitStop
  } state_t;

  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  localparam int unsigned REG_COUNT = 4;

  // Register pointer advance; wraps 3 -> 0 through natural 2-bit overflow.
  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes SCL/SDA into the clk domain and flags SCL edges plus START/STOP conditions.
module i2c_bus_monitor #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl;

  // Reset to ones so an idle bus produces no spurious edges on release.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl      = scl_sync[SYNC_STAGES-1];
  assign sda      = sda_sync[SYNC_STAGES-1];
  assign scl_rise = scl & ~scl_prev;
  assign scl_fall = ~scl & scl_prev;
  assign start    = scl & scl_prev & sda_prev & ~sda;
  assign stop     = scl & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/i2c_target.sv
// I2C target with a 4-byte register bank, shared with an Avalon-MM slave port.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata
);

  logic       sda;
  logic       scl_rise;
  logic       scl_fall;
  logic       start;
  logic       stop;

  state_t     state;
  logic [7:0] shift;
  logic [7:0] tx;
  logic [3:0] bit_cnt;
  logic [1:0] ptr;
  logic       rw;
  logic       phase;
  logic       busy;
  logic [7:0] regs [REG_COUNT];
  logic [7:0] byte_in;
  logic       unused_writedata;

  i2c_bus_monitor #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_monitor (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda      (sda),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  assign byte_in          = {shift[6:0], sda};
  assign readdata         = {23'b0, busy, regs[address]};
  assign unused_writedata = ^writedata[31:8];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= StIdle;
      shift   <= '0;
      tx      <= '0;
      bit_cnt <= '0;
      ptr     <= '0;
      rw      <= 1'b0;
      phase   <= 1'b0;
      busy    <= 1'b0;
      sda_oe  <= 1'b0;
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else begin
      // Avalon write first so a same-cycle I2C write to the same byte overrides it.
      if (chipselect && !write_n) regs[address] <= writedata[7:0];

      if (start) begin
        state   <= StAddr;
        bit_cnt <= '0;
        shift   <= '0;
        phase   <= 1'b0;
        busy    <= 1'b0;
        sda_oe  <= 1'b0;
      end else if (stop) begin
        state  <= StIdle;
        phase  <= 1'b0;
        busy   <= 1'b0;
        sda_oe <= 1'b0;
      end else begin
        case (state)
          StAddr, StPtr, StWdata: begin
            if (scl_rise) begin
              shift   <= byte_in;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                phase   <= 1'b0;
                case (state)
                  StAddr: begin
                    if (byte_in[7:1] == DEV_ADDR) begin
                      rw    <= byte_in[0];
                      busy  <= 1'b1;
                      state <= StAddrAck;
                    end else begin
                      state <= StWaitStop;
                    end
                  end
                  StPtr: begin
                    ptr   <= byte_in[1:0];
                    state <= StPtrAck;
                  end
                  default: begin
                    regs[ptr] <= byte_in;
                    ptr       <= ptr_next(ptr);
                    state     <= StWdataAck;
                  end
                endcase
              end
            end
          end

          StAddrAck, StPtrAck, StWdataAck: begin
            if (scl_fall) begin
              if (!phase) begin
                sda_oe <= ~ACK;
                phase  <= 1'b1;
              end else begin
                phase   <= 1'b0;
                sda_oe  <= 1'b0;
                bit_cnt <= '0;
                if (state == StAddrAck && rw) begin
                  // Ending the ACK slot and presenting the first read bit share one edge.
                  tx     <= regs[ptr];
                  sda_oe <= ~regs[ptr][7];
                  state  <= StRdata;
                end else begin
                  state <= (state == StAddrAck) ? StPtr : StWdata;
                end
              end
            end
          end

          StRdata: begin
            if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe <= 1'b0;
                ptr    <= ptr_next(ptr);
                phase  <= 1'b0;
                state  <= StRdataAck;
              end else begin
                sda_oe <= ~tx[6];
                tx     <= {tx[6:0], 1'b0};
              end
            end
          end

          StRdataAck: begin
            if (scl_rise) begin
              if (sda == NACK) state <= StWaitStop;
              else phase <= 1'b1;
            end
            if (scl_fall && phase) begin
              phase   <= 1'b0;
              tx      <= regs[ptr];
              sda_oe  <= ~regs[ptr][7];
              bit_cnt <= '0;
              state   <= StRdata;
            end
          end

          default: ;
        endcase
      end
    end
  end

endmodule
